// File: rtl/mfi_retire_checker_if.sv
// ---------------------------------------------------------------------------
// mfi_retire_checker_if
// Carries the MFI retirement packet from the core (master) to the retirement
// checker (slave). One packet per cycle while mfi_valid is high; there is no
// ready signal because the checker never stalls the core.
//
// Signals
//   mfi_valid       packet present this cycle
//   mfi_order       packet sequence number
//   mfi_inst        retired instruction word
//   mfi_trap        instruction trapped (destination write discarded)
//   mfi_pc_rdata    PC of the retired instruction
//   mfi_pc_wdata    PC of the next instruction
//   mfi_src1_addr   source 1 register index / mfi_src1_rdata value read
//   mfi_src2_addr   source 2 register index / mfi_src2_rdata value read
//   mfi_dest_addr   destination register index / mfi_dest_wdata value written
// ---------------------------------------------------------------------------
interface mfi_retire_checker_if #(
    parameter int XLEN = 32
);
    logic            mfi_valid;
    logic [XLEN-1:0] mfi_order;
    logic [31:0]     mfi_inst;
    logic            mfi_trap;
    logic [XLEN-1:0] mfi_pc_rdata;
    logic [XLEN-1:0] mfi_pc_wdata;
    logic [3:0]      mfi_src1_addr;
    logic [XLEN-1:0] mfi_src1_rdata;
    logic [3:0]      mfi_src2_addr;
    logic [XLEN-1:0] mfi_src2_rdata;
    logic [3:0]      mfi_dest_addr;
    logic [XLEN-1:0] mfi_dest_wdata;

    modport master (
        output mfi_valid, mfi_order, mfi_inst, mfi_trap,
               mfi_pc_rdata, mfi_pc_wdata,
               mfi_src1_addr, mfi_src1_rdata,
               mfi_src2_addr, mfi_src2_rdata,
               mfi_dest_addr, mfi_dest_wdata
    );

    modport slave (
        input  mfi_valid, mfi_order, mfi_inst, mfi_trap,
               mfi_pc_rdata, mfi_pc_wdata,
               mfi_src1_addr, mfi_src1_rdata,
               mfi_src2_addr, mfi_src2_rdata,
               mfi_dest_addr, mfi_dest_wdata
    );
endinterface

// File: rtl/mfi_retire_checker.sv
// ---------------------------------------------------------------------------
// mfi_retire_checker
// Receiving end of the MFI retirement stream. Keeps a shadow copy of the 16
// architectural registers and checks every retired packet for sequence-number
// continuity, PC continuity and source-operand consistency. All error flags
// are sticky until reset; first_err_order records which packet tripped first.
//
// Optional feature: define MFI_TRACE_FIFO_EN to buffer every accepted packet
// in a FIFO_DEPTH-entry trace FIFO drained through trace_valid/trace_ready.
// Without it the trace outputs and err_overflow are tied to zero.
//
// Ports
//   clock            single clock, all state on posedge
//   reset_n          asynchronous active-low reset
//   mfi              retirement packet stream (slave side)
//   err_order        sticky: order differed from previous order + 1
//   err_pc           sticky: pc_rdata differed from previous pc_wdata
//   err_src          sticky: a source value disagreed with the shadow file
//   err_overflow     sticky: packet dropped because the trace FIFO was full
//   error            OR of all err_* flags
//   first_err_order  mfi_order of the first failing packet
//   retired_count    packets accepted, saturating at all-ones
//   trace_valid      trace FIFO head valid
//   trace_ready      consumer accepts the head entry
//   trace_data       {order, pc_rdata, inst, trap} of the head entry
// ---------------------------------------------------------------------------
module mfi_retire_checker #(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    mfi_retire_checker_if.slave mfi,
    output logic                err_order,
    output logic                err_pc,
    output logic                err_src,
    output logic                err_overflow,
    output logic                error,
    output logic [XLEN-1:0]     first_err_order,
    output logic [CNT_W-1:0]    retired_count,
    output logic                trace_valid,
    input  logic                trace_ready,
    output logic [2*XLEN+32:0]  trace_data
);

    localparam int TRACE_W = 2*XLEN + 33;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            check_seq;

    logic [XLEN-1:0] exp_order;
    logic [XLEN-1:0] exp_pc;
    logic [XLEN-1:0] shadow [16];
    logic [15:0]     known;

    logic            order_bad;
    logic            pc_bad;
    logic            src1_bad;
    logic            src2_bad;
    logic            alias_bad;
    logic            src_bad;
    logic            overflow_now;
    logic            new_err;

    // The first packet after reset only seeds the order/PC expectations;
    // every later packet is checked against them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        check_seq = 1'b0;
        case (state_q)
            IDLE: begin
                if (mfi.mfi_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                check_seq = mfi.mfi_valid;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sources are compared with the shadow as it stood before this packet.
    // Two reads of the same unknown register in one packet must still agree.
    assign order_bad = check_seq && (mfi.mfi_order != exp_order);
    assign pc_bad    = check_seq && (mfi.mfi_pc_rdata != exp_pc);
    assign src1_bad  = known[mfi.mfi_src1_addr]
                       && (mfi.mfi_src1_rdata != shadow[mfi.mfi_src1_addr]);
    assign src2_bad  = known[mfi.mfi_src2_addr]
                       && (mfi.mfi_src2_rdata != shadow[mfi.mfi_src2_addr]);
    assign alias_bad = (mfi.mfi_src1_addr == mfi.mfi_src2_addr)
                       && !known[mfi.mfi_src1_addr]
                       && (mfi.mfi_src1_rdata != mfi.mfi_src2_rdata);
    assign src_bad   = mfi.mfi_valid && (src1_bad || src2_bad || alias_bad);
    assign new_err   = order_bad || pc_bad || src_bad || overflow_now;
    assign error     = err_order || err_pc || err_src || err_overflow;

    // Expectations are reloaded from every packet, including a failing one,
    // so a single glitch in the stream produces one error rather than a cascade.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_order       <= '0;
            exp_pc          <= '0;
            err_order       <= 1'b0;
            err_pc          <= 1'b0;
            err_src         <= 1'b0;
            first_err_order <= '0;
            retired_count   <= '0;
        end else if (mfi.mfi_valid) begin
            exp_order <= mfi.mfi_order + XLEN'(1);
            exp_pc    <= mfi.mfi_pc_wdata;
            if (order_bad) begin
                err_order <= 1'b1;
            end
            if (pc_bad) begin
                err_pc <= 1'b1;
            end
            if (src_bad) begin
                err_src <= 1'b1;
            end
            if (!error && new_err) begin
                first_err_order <= mfi.mfi_order;
            end
            if (retired_count != {CNT_W{1'b1}}) begin
                retired_count <= retired_count + CNT_W'(1);
            end
        end
    end

    // Unknown sources are learned first; the destination write is issued
    // last so it overrides a learned value when dest equals a source.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            known <= '0;
            for (int i = 0; i < 16; i++) begin
                shadow[i] <= '0;
            end
        end else if (mfi.mfi_valid) begin
            if (!known[mfi.mfi_src1_addr]) begin
                shadow[mfi.mfi_src1_addr] <= mfi.mfi_src1_rdata;
                known[mfi.mfi_src1_addr]  <= 1'b1;
            end
            if (!known[mfi.mfi_src2_addr]
                && (mfi.mfi_src2_addr != mfi.mfi_src1_addr)) begin
                shadow[mfi.mfi_src2_addr] <= mfi.mfi_src2_rdata;
                known[mfi.mfi_src2_addr]  <= 1'b1;
            end
            if (!mfi.mfi_trap) begin
                shadow[mfi.mfi_dest_addr] <= mfi.mfi_dest_wdata;
                known[mfi.mfi_dest_addr]  <= 1'b1;
            end
        end
    end

`ifdef MFI_TRACE_FIFO_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [TRACE_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     fifo_count;
    logic               fifo_full;
    logic               pop;
    logic               push_ok;

    // A pop in the same cycle frees the slot, so a full FIFO can still
    // accept the incoming packet without overflowing.
    assign fifo_full    = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign trace_valid  = (fifo_count != '0);
    assign pop          = trace_valid && trace_ready;
    assign push_ok      = mfi.mfi_valid && (!fifo_full || pop);
    assign overflow_now = mfi.mfi_valid && fifo_full && !pop;
    assign trace_data   = trace_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            err_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= {mfi.mfi_order, mfi.mfi_pc_rdata,
                                     mfi.mfi_inst, mfi.mfi_trap};
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (overflow_now) begin
                err_overflow <= 1'b1;
            end
        end
    end
`else
    logic unused_trace;

    // The instruction word and trace_ready only feed the trace FIFO.
    assign unused_trace = ^{mfi.mfi_inst, trace_ready};
    assign overflow_now = 1'b0;
    assign err_overflow = 1'b0;
    assign trace_valid  = 1'b0;
    assign trace_data   = {TRACE_W{1'b0}};
`endif

endmodule

// File: tb/tb_mfi_retire_checker.sv
// ---------------------------------------------------------------------------
// tb_mfi_retire_checker
// Drives directed and randomized retirement packets into mfi_retire_checker
// and compares its flags, counters and trace output against a behavioural
// model of the checking rules kept in this file. CNT_W is reduced so that
// counter saturation is reachable in a few hundred cycles.
// ---------------------------------------------------------------------------
module tb_mfi_retire_checker;

    localparam int XLEN       = 32;
    localparam int CNT_W      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TW         = 2*XLEN + 33;
    localparam int MAX_CNT    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [XLEN-1:0] order;
        logic [31:0]     inst;
        logic [XLEN-1:0] pc_r;
        logic [XLEN-1:0] pc_w;
        logic [3:0]      a1;
        logic [XLEN-1:0] r1;
        logic [3:0]      a2;
        logic [XLEN-1:0] r2;
        logic [3:0]      d;
        logic [XLEN-1:0] wd;
        logic            trap;
    } pkt_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              err_order, err_pc, err_src, err_overflow, error;
    logic [XLEN-1:0]   first_err_order;
    logic [CNT_W-1:0]  retired_count;
    logic              trace_valid;
    logic              trace_ready = 1'b0;
    logic [TW-1:0]     trace_data;

    int checks = 0;
    int passes = 0;

    // Reference model state
    bit              m_started;
    logic [XLEN-1:0] m_exp_order, m_exp_pc, m_first;
    logic [XLEN-1:0] m_shadow [16];
    bit              m_known [16];
    bit              m_err_order, m_err_pc, m_err_src, m_err_ovf;
    int              m_count;
    logic [TW-1:0]   m_fifo [$];

    mfi_retire_checker_if #(.XLEN(XLEN)) mfi ();

    mfi_retire_checker #(.XLEN(XLEN), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .mfi             (mfi),
        .err_order       (err_order),
        .err_pc          (err_pc),
        .err_src         (err_src),
        .err_overflow    (err_overflow),
        .error           (error),
        .first_err_order (first_err_order),
        .retired_count   (retired_count),
        .trace_valid     (trace_valid),
        .trace_ready     (trace_ready),
        .trace_data      (trace_data)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_started = 0; m_exp_order = '0; m_exp_pc = '0; m_first = '0;
        m_err_order = 0; m_err_pc = 0; m_err_src = 0; m_err_ovf = 0;
        m_count = 0;
        for (int i = 0; i < 16; i++) begin
            m_shadow[i] = '0;
            m_known[i]  = 0;
        end
        m_fifo.delete();
    endtask

    // One clock edge of the model: v says whether a packet was presented.
    task automatic model_cycle(input bit v, input pkt_t p);
        bit any_prev, new_err, popped;
        any_prev = m_err_order | m_err_pc | m_err_src | m_err_ovf;
        new_err  = 0;
        popped   = 0;
`ifdef MFI_TRACE_FIFO_EN
        popped = trace_ready && (m_fifo.size() > 0);
`endif
        if (v) begin
            if (m_started && p.order != m_exp_order) begin m_err_order = 1; new_err = 1; end
            if (m_started && p.pc_r != m_exp_pc) begin m_err_pc = 1; new_err = 1; end
            if ((m_known[p.a1] && p.r1 != m_shadow[p.a1]) ||
                (m_known[p.a2] && p.r2 != m_shadow[p.a2]) ||
                (p.a1 == p.a2 && !m_known[p.a1] && p.r1 != p.r2)) begin
                m_err_src = 1; new_err = 1;
            end
            if (!m_known[p.a1]) begin m_shadow[p.a1] = p.r1; m_known[p.a1] = 1; end
            if (!m_known[p.a2]) begin m_shadow[p.a2] = p.r2; m_known[p.a2] = 1; end
            if (!p.trap) begin m_shadow[p.d] = p.wd; m_known[p.d] = 1; end
            m_started   = 1;
            m_exp_order = p.order + 1;
            m_exp_pc    = p.pc_w;
            if (m_count < MAX_CNT) m_count++;
`ifdef MFI_TRACE_FIFO_EN
            if (m_fifo.size() == FIFO_DEPTH && !popped) begin
                m_err_ovf = 1; new_err = 1;
            end else begin
                m_fifo.push_back({p.order, p.pc_r, p.inst, p.trap});
            end
`endif
            if (!any_prev && new_err) m_first = p.order;
        end
        if (popped) void'(m_fifo.pop_front());
    endtask

    // Builds a packet that obeys every rule given the model's current state.
    function automatic pkt_t good_packet();
        pkt_t p;
        p.order = m_started ? m_exp_order : $urandom;
        p.pc_r  = m_started ? m_exp_pc : $urandom;
        p.pc_w  = p.pc_r + 4;
        p.inst  = $urandom;
        p.a1    = 4'($urandom);
        p.a2    = 4'($urandom);
        p.r1    = m_known[p.a1] ? m_shadow[p.a1] : $urandom;
        p.r2    = (p.a2 == p.a1) ? p.r1 : (m_known[p.a2] ? m_shadow[p.a2] : $urandom);
        p.d     = 4'($urandom);
        p.wd    = $urandom;
        p.trap  = 1'b0;
        return p;
    endfunction

    task automatic drive_packet(input pkt_t p);
        mfi.mfi_valid      = 1'b1;
        mfi.mfi_order      = p.order;
        mfi.mfi_inst       = p.inst;
        mfi.mfi_trap       = p.trap;
        mfi.mfi_pc_rdata   = p.pc_r;
        mfi.mfi_pc_wdata   = p.pc_w;
        mfi.mfi_src1_addr  = p.a1;
        mfi.mfi_src1_rdata = p.r1;
        mfi.mfi_src2_addr  = p.a2;
        mfi.mfi_src2_rdata = p.r2;
        mfi.mfi_dest_addr  = p.d;
        mfi.mfi_dest_wdata = p.wd;
        @(posedge clock);
        model_cycle(1'b1, p);
        #1;
        mfi.mfi_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        pkt_t p;
        p = '0;
        mfi.mfi_valid = 1'b0;
        @(posedge clock);
        model_cycle(1'b0, p);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        mfi.mfi_valid = 1'b0;
        model_reset();
        #12;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (err_order !== 1'b0) $display("[TB] FAIL reset_err_order: got %b expected 0", err_order); else passes++;
        checks++; if (err_pc !== 1'b0) $display("[TB] FAIL reset_err_pc: got %b expected 0", err_pc); else passes++;
        checks++; if (err_src !== 1'b0) $display("[TB] FAIL reset_err_src: got %b expected 0", err_src); else passes++;
        checks++; if (err_overflow !== 1'b0) $display("[TB] FAIL reset_err_overflow: got %b expected 0", err_overflow); else passes++;
        checks++; if (error !== 1'b0) $display("[TB] FAIL reset_error: got %b expected 0", error); else passes++;
        checks++; if (first_err_order !== '0) $display("[TB] FAIL reset_first_err: got %h expected 0", first_err_order); else passes++;
        checks++; if (retired_count !== '0) $display("[TB] FAIL reset_count: got %0d expected 0", retired_count); else passes++;
        checks++; if (trace_valid !== 1'b0) $display("[TB] FAIL reset_trace_valid: got %b expected 0", trace_valid); else passes++;
    endtask

    task automatic test_in_order();
        pkt_t p;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            p = good_packet();
            p.order = 32'd5 + i;
            p.pc_r  = 32'h100 + 4*i;
            p.pc_w  = p.pc_r + 4;
            drive_packet(p);
        end
        checks++; if (error !== 1'b0) $display("[TB] FAIL in_order_error: got %b expected 0", error); else passes++;
        checks++; if (retired_count !== CNT_W'(3)) $display("[TB] FAIL in_order_count: got %0d expected 3", retired_count); else passes++;
    endtask

    task automatic test_order_gap();
        pkt_t p;
        do_reset();
        p = good_packet(); p.order = 32'd5; drive_packet(p);
        p = good_packet(); p.order = 32'd7; drive_packet(p);
        checks++; if (err_order !== 1'b1) $display("[TB] FAIL gap_err_order: got %b expected 1", err_order); else passes++;
        checks++; if (first_err_order !== 32'd7) $display("[TB] FAIL gap_first_err: got %h expected 7", first_err_order); else passes++;
        p = good_packet(); p.order = 32'd8; drive_packet(p);
        checks++; if ({err_pc, err_src} !== 2'b00) $display("[TB] FAIL gap_no_new_err: got %b expected 00", {err_pc, err_src}); else passes++;
        checks++; if (first_err_order !== 32'd7) $display("[TB] FAIL gap_first_held: got %h expected 7", first_err_order); else passes++;
    endtask

    task automatic test_src_mismatch();
        pkt_t p;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            p = good_packet();
            p.a1 = 4'd1; p.a2 = 4'd1; p.r2 = p.r1;
            p.d = 4'd3; p.wd = 32'hDEADBEEF; p.trap = (t == 1);
            drive_packet(p);
            p = good_packet();
            p.a1 = 4'd3; p.r1 = 32'hDEADBEEE; p.a2 = 4'd4; p.r2 = $urandom;
            drive_packet(p);
            checks++; if (err_src !== (t == 0)) $display("[TB] FAIL src_mismatch_trap%0d: got %b expected %b", t, err_src, (t == 0)); else passes++;
            checks++; if (err_src !== m_err_src) $display("[TB] FAIL src_model_trap%0d: got %b expected %b", t, err_src, m_err_src); else passes++;
        end
    endtask

    task automatic test_pc_reset();
        pkt_t p;
        do_reset();
        p = good_packet(); p.pc_w = 32'h200; drive_packet(p);
        p = good_packet(); p.pc_r = 32'h204; p.pc_w = 32'h208; drive_packet(p);
        checks++; if (err_pc !== 1'b1) $display("[TB] FAIL pc_err: got %b expected 1", err_pc); else passes++;
        checks++; if (first_err_order !== p.order) $display("[TB] FAIL pc_first_err: got %h expected %h", first_err_order, p.order); else passes++;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({error, err_pc, retired_count} !== '0) $display("[TB] FAIL async_reset_clear: got %b/%b/%0d expected 0", error, err_pc, retired_count); else passes++;
        @(negedge clock);
        reset_n = 1'b1;
        p = good_packet(); p.order = 32'd100; p.pc_r = 32'h999; p.pc_w = 32'h99D;
        drive_packet(p);
        p = good_packet(); drive_packet(p);
        checks++; if (error !== 1'b0) $display("[TB] FAIL after_reset_error: got %b expected 0", error); else passes++;
    endtask

    task automatic test_order_wrap();
        pkt_t p;
        do_reset();
        p = good_packet(); p.order = 32'hFFFFFFFF; drive_packet(p);
        p = good_packet(); p.order = 32'h00000000; drive_packet(p);
        checks++; if (err_order !== 1'b0) $display("[TB] FAIL order_wrap: got %b expected 0", err_order); else passes++;
    endtask

    task automatic test_saturation();
        pkt_t p;
        do_reset();
        for (int i = 1; i <= MAX_CNT + 3; i++) begin
            trace_ready = 1'b1;
            p = good_packet();
            drive_packet(p);
            if (i == MAX_CNT - 1) begin
                checks++; if (retired_count !== CNT_W'(MAX_CNT - 1)) $display("[TB] FAIL count_below_max: got %0d expected %0d", retired_count, MAX_CNT - 1); else passes++;
            end
        end
        checks++; if (retired_count !== {CNT_W{1'b1}}) $display("[TB] FAIL count_saturated: got %0d expected %0d", retired_count, MAX_CNT); else passes++;
        checks++; if (retired_count !== CNT_W'(m_count)) $display("[TB] FAIL count_model: got %0d expected %0d", retired_count, m_count); else passes++;
        trace_ready = 1'b0;
    endtask

    task automatic test_trace_fifo();
        pkt_t p;
        logic [TW-1:0] sent [$];
`ifdef MFI_TRACE_FIFO_EN
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            p = good_packet(); drive_packet(p);
            sent.push_back({p.order, p.pc_r, p.inst, p.trap});
        end
        checks++; if (err_overflow !== 1'b1) $display("[TB] FAIL fifo_overflow: got %b expected 1", err_overflow); else passes++;
        checks++; if (first_err_order !== sent[4][TW-1 -: XLEN]) $display("[TB] FAIL fifo_first_err: got %h expected %h", first_err_order, sent[4][TW-1 -: XLEN]); else passes++;
        trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (trace_data !== sent[i] || trace_valid !== 1'b1) $display("[TB] FAIL fifo_drain%0d: got %b/%h expected 1/%h", i, trace_valid, trace_data, sent[i]); else passes++;
            idle_cycle();
        end
        checks++; if (trace_valid !== 1'b0) $display("[TB] FAIL fifo_empty: got %b expected 0", trace_valid); else passes++;
        do_reset();
        sent.delete();
        trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p = good_packet(); drive_packet(p);
            sent.push_back({p.order, p.pc_r, p.inst, p.trap});
        end
        trace_ready = 1'b1;
        p = good_packet(); drive_packet(p);
        sent.push_back({p.order, p.pc_r, p.inst, p.trap});
        checks++; if (err_overflow !== 1'b0) $display("[TB] FAIL fifo_push_pop_full: got %b expected 0", err_overflow); else passes++;
        checks++; if (trace_data !== sent[1]) $display("[TB] FAIL fifo_head_after_pop: got %h expected %h", trace_data, sent[1]); else passes++;
        trace_ready = 1'b0;
`else
        do_reset();
        trace_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p = good_packet(); drive_packet(p);
            checks++; if ({trace_valid, trace_data, err_overflow} !== '0) $display("[TB] FAIL no_fifo_outputs%0d: got %b/%h/%b expected 0", i, trace_valid, trace_data, err_overflow); else passes++;
        end
        trace_ready = 1'b0;
        sent.delete();
`endif
    endtask

    task automatic test_random();
        pkt_t p;
        logic [TW-1:0] exp_data;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            trace_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 4) != 0) begin
                p = good_packet();
                if ($urandom_range(0, 150) == 0) p.order = p.order + 2;
                if ($urandom_range(0, 150) == 0) p.pc_r  = p.pc_r ^ 32'h10;
                if ($urandom_range(0, 150) == 0) p.r1    = p.r1 ^ 32'h1;
                p.trap = ($urandom_range(0, 9) == 0);
                drive_packet(p);
            end else begin
                idle_cycle();
            end
            exp_data = (m_fifo.size() > 0) ? m_fifo[0] : '0;
            checks++; if (err_order !== m_err_order) $display("[TB] FAIL rnd_err_order@%0d: got %b expected %b", n, err_order, m_err_order); else passes++;
            checks++; if (err_pc !== m_err_pc) $display("[TB] FAIL rnd_err_pc@%0d: got %b expected %b", n, err_pc, m_err_pc); else passes++;
            checks++; if (err_src !== m_err_src) $display("[TB] FAIL rnd_err_src@%0d: got %b expected %b", n, err_src, m_err_src); else passes++;
            checks++; if (err_overflow !== m_err_ovf) $display("[TB] FAIL rnd_err_ovf@%0d: got %b expected %b", n, err_overflow, m_err_ovf); else passes++;
            checks++; if (error !== (m_err_order | m_err_pc | m_err_src | m_err_ovf)) $display("[TB] FAIL rnd_error@%0d: got %b", n, error); else passes++;
            checks++; if (first_err_order !== m_first) $display("[TB] FAIL rnd_first@%0d: got %h expected %h", n, first_err_order, m_first); else passes++;
            checks++; if (retired_count !== CNT_W'(m_count)) $display("[TB] FAIL rnd_count@%0d: got %0d expected %0d", n, retired_count, m_count); else passes++;
            checks++; if (trace_valid !== (m_fifo.size() > 0) || trace_data !== exp_data) $display("[TB] FAIL rnd_trace@%0d: got %b/%h expected %h", n, trace_valid, trace_data, exp_data); else passes++;
        end
        trace_ready = 1'b0;
    endtask

    // Directed scenarios first, then a randomized soak against the model.
    initial begin
        mfi.mfi_valid = 1'b0;
        model_reset();
        test_reset();
        test_in_order();
        test_order_gap();
        test_src_mismatch();
        test_pc_reset();
        test_order_wrap();
        test_saturation();
        test_trace_fifo();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
